// File: rtl/aes256_if.sv
// Host-side bundle for the AES-256 encryption core.
// The host drives block, key and start; the core returns ciphertext and a done pulse.
interface aes256_if;
    logic         ready;
    logic [127:0] data_in;
    logic [255:0] key;
    logic [127:0] data_out;
    logic         valid;

    modport master (
        output ready, data_in, key,
        input  data_out, valid
    );

    modport slave (
        input  ready, data_in, key,
        output data_out, valid
    );
endinterface

// File: rtl/aes256_encrypt.sv
// Iterative AES-256 encryption core: one round per clock.
// The round keys are expanded on the fly from a sliding 256-bit key window.
module aes256_encrypt #(
    parameter int NR = 14
) (
    input  logic     clk,
    input  logic     reset,
    aes256_if.slave  bus
);

    typedef enum logic {IDLE, BUSY} fsm_t;

    fsm_t           state_q, state_d;
    logic [3:0]     round_q;
    logic [127:0]   st_q;
    logic [255:0]   kwin_q;
    logic [127:0]   data_out_q;
    logic           valid_q;
    logic           load, last;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as x^254 (squares x^2..x^128 multiplied together), then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Next 128-bit half of the schedule from the two previous halves.
    // Even halves (w[i], i%8==0) rotate and add Rcon; odd halves only substitute.
    function automatic logic [127:0] next_half(
        input logic [127:0] prev,
        input logic [127:0] cur,
        input logic         even,
        input logic [7:0]   rc
    );
        logic [31:0] t, w0, w1, w2, w3;
        t = cur[31:0];
        if (even) t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        else      t = sub_word(t);
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] rk, sr, mc, nk;
    logic [7:0]   rcon;

    assign rk   = kwin_q[127:0];
    assign rcon = 8'h01 << ((round_q - 4'd1) >> 1);
    assign sr   = shift_rows(sub_bytes(st_q));
    assign mc   = mix_columns(sr);
    assign nk   = next_half(kwin_q[255:128], kwin_q[127:0], round_q[0], rcon);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: if (bus.ready) begin
                state_d = BUSY;
                load    = 1'b1;
            end
            BUSY: if (round_q == 4'(NR)) begin
                state_d = IDLE;
                last    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            round_q    <= 4'd0;
            st_q       <= '0;
            kwin_q     <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= last;
            if (load) begin
                st_q    <= bus.data_in ^ bus.key[255:128];
                kwin_q  <= bus.key;
                round_q <= 4'd1;
            end else if (last) begin
                data_out_q <= sr ^ rk;
                round_q    <= 4'd0;
            end else if (state_q == BUSY) begin
                st_q    <= mc ^ rk;
                kwin_q  <= {kwin_q[127:0], nk};
                round_q <= round_q + 4'd1;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.valid    = valid_q;

endmodule

// File: tb/tb_aes256_encrypt.sv
// Scoreboard bench for aes256_encrypt: the driver queues expected ciphertext
// and completion cycle, and the monitor checks every valid pulse against it.
module tb_aes256_encrypt;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    localparam logic [255:0] K1 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CZ = 128'hdc95c078a2408989ad48a21492842087;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    aes256_if bus();

    aes256_encrypt dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected block.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ciphertext", bus.data_out, e.data);
                check("latency_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    task automatic start(input logic [127:0] d, input logic [255:0] k,
                         input bit expect_done, output int e0);
        @(negedge clk);
        bus.data_in = d;
        bus.key     = k;
        bus.ready   = 1'b1;
        e0 = cyc + 1;
        if (expect_done)
            sb.push_back('{data: (k == K1 && d == P1) ? C1 : CZ, cyc: e0 + 14});
        @(negedge clk);
        bus.ready = 1'b0;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int e0;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.ready   = 1'b0;
        bus.data_in = '0;
        bus.key     = '0;

        // Reset for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_data_out", bus.data_out, 128'd0);
        check("reset_valid", 128'(bus.valid), 128'd0);
        reset = 1'b0;

        // FIPS-197 C.3, then hold for 50 cycles.
        start(P1, K1, 1'b1, e0);
        bus.data_in = '0;
        bus.key     = '0;
        wait_until(e0 + 14);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("hold_valid", 128'(bus.valid), 128'd0);
            check("hold_data_out", bus.data_out, C1);
        end

        // All-zero vector.
        start('0, '0, 1'b1, e0);
        wait_until(e0 + 16);

        // Abort mid-block with reset; no valid may follow.
        start(P1, K1, 1'b0, e0);
        wait_until(e0 + 6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_data_out", bus.data_out, 128'd0);
        check("abort_valid", 128'(bus.valid), 128'd0);
        repeat (20) @(negedge clk);

        // Fresh start after abort.
        start(P1, K1, 1'b1, e0);
        wait_until(e0 + 16);

        // ready held high: one block per 15 clocks; inputs change mid-block.
        @(negedge clk);
        bus.data_in = P1;
        bus.key     = K1;
        bus.ready   = 1'b1;
        e0 = cyc + 1;
        sb.push_back('{data: C1, cyc: e0 + 14});
        sb.push_back('{data: C1, cyc: e0 + 29});
        sb.push_back('{data: CZ, cyc: e0 + 44});
        wait_until(e0 + 20);
        bus.data_in = '0;
        bus.key     = '0;
        wait_until(e0 + 44);
        bus.ready = 1'b0;

        // Drain with a bounded wait.
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
